// File: rtl/mux_2_1_rr_arbiter.sv
// Round-robin arbiter sharing one 2:1 mux datapath between requesters A and B.
// A forced rotation after MAX_HOLD contended cycles keeps either side from starving.
// The selected word is registered and tagged with out_valid.
module mux_2_1_rr_arbiter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             sel,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid
);

  localparam int unsigned CntW = $clog2(MAX_HOLD) + 1;
  localparam logic [CntW-1:0] HoldLast = CntW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StGntA = 2'd1,
    StGntB = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   hold_cnt_q, hold_cnt_d;
  logic              last_a_q, last_a_d;  // 1: A was granted most recently
  logic              sel_q, sel_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;

  // Next-state arbitration, hold counter and datapath capture.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    last_a_d    = last_a_q;
    sel_d       = sel_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_a && req_b) begin
          state_d = last_a_q ? StGntB : StGntA;
        end else if (req_a) begin
          state_d = StGntA;
        end else if (req_b) begin
          state_d = StGntB;
        end
      end
      StGntA: begin
        if (!req_a) begin
          state_d = req_b ? StGntB : StIdle;
        end else if (req_b && (hold_cnt_q == HoldLast)) begin
          state_d = StGntB;
        end
      end
      StGntB: begin
        if (!req_b) begin
          state_d = req_a ? StGntA : StIdle;
        end else if (req_a && (hold_cnt_q == HoldLast)) begin
          state_d = StGntA;
        end
      end
      default: state_d = StIdle;
    endcase

    // Counter only advances on contended cycles of an unchanged tenure.
    if (state_d != state_q) begin
      hold_cnt_d = '0;
      if (state_d == StGntA) last_a_d = 1'b1;
      if (state_d == StGntB) last_a_d = 1'b0;
    end else if ((state_q == StGntA && req_b) || (state_q == StGntB && req_a)) begin
      hold_cnt_d = hold_cnt_q + CntW'(1);
    end

    // Select holds its last value while idle.
    if (state_d == StGntA) sel_d = 1'b1;
    if (state_d == StGntB) sel_d = 1'b0;

    out_data_d  = sel_d ? in_a : in_b;
    out_valid_d = ((state_d == StGntA) && req_a) || ((state_d == StGntB) && req_b);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      hold_cnt_q  <= '0;
      last_a_q    <= 1'b0;
      sel_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      last_a_q    <= last_a_d;
      sel_q       <= sel_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign gnt_a     = (state_q == StGntA);
  assign gnt_b     = (state_q == StGntB);
  assign sel       = sel_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_2_1_rr_arbiter.sv
// Self-checking bench for mux_2_1_rr_arbiter: directed vector table, hand-written
// corner sequences, then randomized requests with invariant checkers.
module tb_mux_2_1_rr_arbiter;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned MAX_HOLD = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_a, req_b;
  logic [WIDTH-1:0] in_a, in_b;
  logic             gnt_a, gnt_b, sel, out_valid;
  logic [WIDTH-1:0] out_data;

  int errors = 0;
  int checks = 0;

  mux_2_1_rr_arbiter #(
    .WIDTH    (WIDTH),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_a     (req_a),
    .req_b     (req_b),
    .in_a      (in_a),
    .in_b      (in_b),
    .gnt_a     (gnt_a),
    .gnt_b     (gnt_b),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ra;
    logic       rb;
    logic [7:0] a;
    logic [7:0] b;
    logic       ga;
    logic       gb;
    logic       s;
    logic       v;
    logic [7:0] d;
  } vec_t;

  localparam int NVec = 23;
  vec_t vecs [NVec];

  function automatic vec_t mk(input logic ra, input logic rb, input logic [7:0] a,
                              input logic [7:0] b, input logic ga, input logic gb,
                              input logic s, input logic v, input logic [7:0] d);
    vec_t r;
    r.ra = ra; r.rb = rb; r.a = a; r.b = b;
    r.ga = ga; r.gb = gb; r.s = s; r.v = v; r.d = d;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic ga, input logic gb, input logic s,
                         input logic v, input logic [7:0] d);
    chk({tag, ".gnt_a"}, {31'd0, gnt_a}, {31'd0, ga});
    chk({tag, ".gnt_b"}, {31'd0, gnt_b}, {31'd0, gb});
    chk({tag, ".sel"}, {31'd0, sel}, {31'd0, s});
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({tag, ".out_data"}, {24'd0, out_data}, {24'd0, d});
  endtask

  initial begin
    // Sequence starts from reset: IDLE, last=B, sel=0.
    vecs[0]  = mk(1, 0, 8'h5A, 8'h11, 1, 0, 1, 1, 8'h5A);
    vecs[1]  = mk(1, 1, 8'h01, 8'hF1, 1, 0, 1, 1, 8'h01);
    vecs[2]  = mk(1, 1, 8'h02, 8'hF2, 1, 0, 1, 1, 8'h02);
    vecs[3]  = mk(1, 1, 8'h03, 8'hF3, 1, 0, 1, 1, 8'h03);
    vecs[4]  = mk(1, 1, 8'h04, 8'hB4, 0, 1, 0, 1, 8'hB4);  // forced rotation
    vecs[5]  = mk(1, 1, 8'h05, 8'hB5, 0, 1, 0, 1, 8'hB5);
    vecs[6]  = mk(1, 1, 8'h06, 8'hB6, 0, 1, 0, 1, 8'hB6);
    vecs[7]  = mk(1, 1, 8'h07, 8'hB7, 0, 1, 0, 1, 8'hB7);
    vecs[8]  = mk(1, 1, 8'h08, 8'hB8, 1, 0, 1, 1, 8'h08);  // rotate back to A
    vecs[9]  = mk(0, 1, 8'h09, 8'hB9, 0, 1, 0, 1, 8'hB9);  // A drops, B direct
    vecs[10] = mk(0, 1, 8'h0A, 8'hBA, 0, 1, 0, 1, 8'hBA);
    vecs[11] = mk(0, 1, 8'h0B, 8'hBB, 0, 1, 0, 1, 8'hBB);
    vecs[12] = mk(1, 1, 8'h0C, 8'hBC, 0, 1, 0, 1, 8'hBC);
    vecs[13] = mk(1, 1, 8'h0D, 8'hBD, 0, 1, 0, 1, 8'hBD);
    vecs[14] = mk(1, 1, 8'h0E, 8'hBE, 0, 1, 0, 1, 8'hBE);
    vecs[15] = mk(1, 1, 8'h0F, 8'hBF, 1, 0, 1, 1, 8'h0F);
    vecs[16] = mk(0, 0, 8'h77, 8'hC0, 0, 0, 1, 0, 8'h77);  // drop: word not valid
    vecs[17] = mk(0, 0, 8'h78, 8'hC1, 0, 0, 1, 0, 8'h78);
    vecs[18] = mk(1, 1, 8'h20, 8'hD0, 0, 1, 0, 1, 8'hD0);  // tie after A: B wins
    vecs[19] = mk(0, 0, 8'h21, 8'hD1, 0, 0, 0, 0, 8'hD1);
    vecs[20] = mk(0, 1, 8'h22, 8'hD2, 0, 1, 0, 1, 8'hD2);
    vecs[21] = mk(1, 0, 8'h23, 8'hD3, 1, 0, 1, 1, 8'h23);  // B drops, A direct
    vecs[22] = mk(1, 0, 8'h24, 8'hD4, 1, 0, 1, 1, 8'h24);

    rst = 1'b1; req_a = 1'b0; req_b = 1'b0; in_a = 8'h33; in_b = 8'h44;
    step();
    step();
    chk_out("reset", 0, 0, 0, 0, 8'h00);
    rst = 1'b0;

    for (int i = 0; i < NVec; i++) begin
      req_a = vecs[i].ra; req_b = vecs[i].rb; in_a = vecs[i].a; in_b = vecs[i].b;
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].ga, vecs[i].gb, vecs[i].s, vecs[i].v, vecs[i].d);
    end

    // Long uncontended B tenure: no rotation, counter must stay at zero.
    req_a = 1'b0; req_b = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_a = 8'(i); in_b = 8'(8'h60 + i);
      step();
      chk_out($sformatf("longb%0d", i), 0, 1, 0, 1, 8'(8'h60 + i));
    end
    // Contention now: B keeps MAX_HOLD-1 more edges, rotation on the next.
    req_a = 1'b1;
    for (int i = 0; i < int'(MAX_HOLD) - 1; i++) begin
      in_b = 8'(8'h90 + i);
      step();
      chk_out($sformatf("contb%0d", i), 0, 1, 0, 1, 8'(8'h90 + i));
    end
    in_a = 8'hA5;
    step();
    chk_out("contb_rot", 1, 0, 1, 1, 8'hA5);

    // Reset in the middle of a valid B transfer.
    req_a = 1'b0; req_b = 1'b1; in_b = 8'hE7;
    step();
    chk_out("pre_rst", 0, 1, 0, 1, 8'hE7);
    rst = 1'b1; req_a = 1'b1; in_a = 8'hAA; in_b = 8'hBB;
    step();
    chk_out("mid_rst", 0, 0, 0, 0, 8'h00);
    rst = 1'b0;
    step();
    chk_out("post_rst", 1, 0, 1, 1, 8'hAA);

    // Randomized requests with invariant checks.
    begin
      logic       p_ga, p_gb, p_ra, p_rb;
      logic [7:0] p_a, p_b;
      int         cnt_a, cnt_b;
      cnt_a = 0; cnt_b = 0;
      for (int i = 0; i < 10000; i++) begin
        req_a = 1'($urandom_range(0, 1));
        req_b = 1'($urandom_range(0, 1));
        in_a  = 8'($urandom);
        in_b  = 8'($urandom);
        p_ga = gnt_a; p_gb = gnt_b; p_ra = req_a; p_rb = req_b; p_a = in_a; p_b = in_b;
        step();
        chk("rnd.onehot", {31'd0, gnt_a & gnt_b}, 32'd0);
        if (out_valid) begin
          chk("rnd.data", {24'd0, out_data}, {24'd0, (sel ? p_a : p_b)});
          chk("rnd.valid_owner",
              {31'd0, (gnt_a & sel & p_ra) | (gnt_b & ~sel & p_rb)}, 32'd1);
        end
        // Contended stays since entry into the current tenure.
        if (!p_ga) cnt_a = 0;
        else if (gnt_a && p_ra && p_rb) cnt_a++;
        if (!p_gb) cnt_b = 0;
        else if (gnt_b && p_ra && p_rb) cnt_b++;
        if (!gnt_a) cnt_a = 0;
        if (!gnt_b) cnt_b = 0;
        if (p_ga && p_ra && p_rb) chk("rnd.hold_a", {31'd0, cnt_a < int'(MAX_HOLD)}, 32'd1);
        if (p_gb && p_ra && p_rb) chk("rnd.hold_b", {31'd0, cnt_b < int'(MAX_HOLD)}, 32'd1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
